spi_master_param: RTL and testbench

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_master_param.sv | 152 +++++++++++++++
 tb/tb_spi_master_param.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI master types: controller state encoding and chip-select width helper.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_HOLD
    } state_t;

    function automatic int cs_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SPI half-period timer: counts clk cycles while enabled, ticks on the last one.
module spi_clk_div #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_param.sv
// Parameterised SPI master: one word per request, all four modes,
// post-reset hold-off and per-transfer chip-select.
module spi_master_param
    import spi_pkg::*;
#(
    parameter  int DATA_W   = 8,
    parameter  int CLK_DIV  = 50,
    parameter  int NUM_CS   = 1,
    parameter  int RST_HOLD = 20,
    localparam int CS_W     = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam int IW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_t            state;
    state_t            state_nx;
    logic              tick;
    logic              busy;
    logic              last_edge;
    logic              lead;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CS_W-1:0]   sel_q;
    logic              pol_q;
    logic              pha_q;
    logic              sck_q;
    logic              mosi_q;
    logic [EW-1:0]     edge_cnt;
    logic [IW-1:0]     init_cnt;

    assign busy      = (state == ST_SETUP) || (state == ST_XFER) ||
                       (state == ST_HOLD);
    assign last_edge = (edge_cnt == EW'(2 * DATA_W - 1));
    // Even edge numbers leave the idle level, odd ones return to it.
    assign lead      = ~edge_cnt[0];

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_div (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .tick (tick)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_INIT:  if (init_cnt == IW'(RST_HOLD - 1)) state_nx = ST_IDLE;
            ST_IDLE:  if (start) state_nx = ST_SETUP;
            ST_SETUP: if (tick) state_nx = ST_XFER;
            ST_XFER:  if (tick && last_edge) state_nx = ST_HOLD;
            ST_HOLD:  if (tick) state_nx = ST_IDLE;
            default:  state_nx = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            sel_q    <= '0;
            pol_q    <= 1'b0;
            pha_q    <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_INIT) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (state == ST_IDLE && start) begin
                sel_q    <= cs_sel;
                pol_q    <= cpol;
                pha_q    <= cpha;
                sck_q    <= cpol;
                edge_cnt <= '0;
                // cpha=0 presents the MSB before the first edge.
                if (cpha) begin
                    tx_sh  <= tx_data;
                    mosi_q <= 1'b0;
                end else begin
                    tx_sh  <= {tx_data[DATA_W-2:0], 1'b0};
                    mosi_q <= tx_data[DATA_W-1];
                end
            end
            if (state == ST_XFER && tick) begin
                sck_q    <= ~sck_q;
                edge_cnt <= edge_cnt + 1'b1;
                if (lead == pha_q) begin
                    mosi_q <= tx_sh[DATA_W-1];
                    tx_sh  <= {tx_sh[DATA_W-2:0], 1'b0};
                end else begin
                    rx_sh <= {rx_sh[DATA_W-2:0], miso};
                end
            end
            if (state == ST_HOLD && tick) begin
                rx_data <= rx_sh;
                done    <= 1'b1;
                mosi_q  <= 1'b0;
            end
        end
    end

    assign ready = (state == ST_IDLE);
    assign mosi  = busy ? mosi_q : 1'b0;

    always_comb begin
        sck = 1'b0;
        if (state == ST_IDLE) begin
            sck = cpol;
        end else if (busy) begin
            sck = sck_q;
        end
    end

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && sel_q == CS_W'(i)) cs_n[i] = 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: cycle model for an 8-bit/3-CS instance,
// directed checks on a 16-bit/4-CS instance.
module tb_spi_master_param;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int H  = 20;
    localparam int TB = (2 * W + 2) * D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0;
    logic        start_b = 1'b0;
    logic [15:0] tx = '0;
    logic [1:0]  sel = '0;
    logic        pol = 1'b0;
    logic        pha = 1'b0;
    logic        loop_a = 1'b1;
    logic [7:0]  slv = '0;

    logic        ready_a, done_a, sck_a, mosi_a, miso_a;
    logic [7:0]  rx_a;
    logic [2:0]  cs_a;
    logic        ready_b, done_b, sck_b, mosi_b, miso_b;
    logic [15:0] rx_b;
    logic [3:0]  cs_b;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_master_param #(
        .DATA_W(8), .CLK_DIV(4), .NUM_CS(3), .RST_HOLD(20)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .tx_data(tx[7:0]),
        .cs_sel(sel), .cpol(pol), .cpha(pha), .ready(ready_a),
        .done(done_a), .rx_data(rx_a), .sck(sck_a), .mosi(mosi_a),
        .miso(miso_a), .cs_n(cs_a)
    );

    spi_master_param #(
        .DATA_W(16), .CLK_DIV(2), .NUM_CS(4), .RST_HOLD(20)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .tx_data(tx),
        .cs_sel(sel), .cpol(pol), .cpha(pha), .ready(ready_b),
        .done(done_b), .rx_data(rx_b), .sck(sck_b), .mosi(mosi_b),
        .miso(miso_b), .cs_n(cs_b)
    );

    assign miso_b = mosi_b;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Slave device for instance A, answering with slv in the current mode.
    logic s_miso = 1'b0;
    logic s_prev = 1'b0;
    logic s_cpol = 1'b0;
    logic s_cpha = 1'b0;
    bit   s_act = 0;
    int   s_idx = 0;

    always @(negedge clk) begin
        if (cs_a == 3'b111) begin
            s_act  = 0;
            s_miso = 1'b0;
        end else if (!s_act) begin
            s_act  = 1;
            s_prev = sck_a;
            s_idx  = 7;
            if (!s_cpha) begin
                s_miso = slv[7];
                s_idx  = 6;
            end
        end else if (sck_a != s_prev) begin
            if (((s_prev == s_cpol) == s_cpha) && s_idx >= 0) begin
                s_miso = slv[s_idx];
                s_idx--;
            end
            s_prev = sck_a;
        end
    end

    assign miso_a = loop_a ? mosi_a : s_miso;

    // Transfer-level model of instance A, checked every cycle.
    int         m_init = 0;
    int         m_t = 0;
    int         tgl;
    bit         m_busy = 0;
    bit         m_done = 0;
    logic [7:0] m_rx = '0;
    logic [7:0] m_exp = '0;
    logic [1:0] m_sel = '0;
    logic       m_pol = 1'b0;
    logic [2:0] e_cs;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init = 0;
            m_busy = 0;
            m_done = 0;
            m_rx   = '0;
        end else begin
            m_done = 0;
            if (m_init < H) begin
                m_init++;
            end else if (m_busy) begin
                m_t++;
                if (m_t == TB) begin
                    m_busy = 0;
                    m_done = 1;
                    m_rx   = m_exp;
                end
            end else if (start_a) begin
                m_busy = 1;
                m_t    = 0;
                m_sel  = sel;
                m_pol  = pol;
                m_exp  = loop_a ? tx[7:0] : slv;
            end
        end
        #1;
        if (!rst_n || m_init < H) begin
            chk("m_init_ready", ready_a, 0);
            chk("m_init_done", done_a, 0);
            chk("m_init_cs", cs_a, 3'b111);
            chk("m_init_sck", sck_a, 0);
            chk("m_init_mosi", mosi_a, 0);
        end else if (m_busy) begin
            tgl = m_t / D - 1;
            if (tgl < 0) tgl = 0;
            if (tgl > 2 * W) tgl = 2 * W;
            e_cs = 3'b111;
            if (m_sel < 2'd3) e_cs[m_sel] = 1'b0;
            chk("m_busy_ready", ready_a, 0);
            chk("m_busy_done", done_a, 0);
            chk("m_busy_cs", cs_a, e_cs);
            chk("m_busy_sck", sck_a, m_pol ^ (tgl % 2 == 1));
        end else begin
            chk("m_idle_ready", ready_a, 1);
            chk("m_idle_done", done_a, m_done);
            chk("m_idle_cs", cs_a, 3'b111);
            chk("m_idle_sck", sck_a, pol);
            chk("m_idle_mosi", mosi_a, 0);
        end
        chk("m_rx", rx_a, m_rx);
    end

    task automatic wait_ready_a();
        int k = 0;
        while (!ready_a && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("ready_a_wait", ready_a, 1);
    endtask

    // lat counts rising edges from the start-sample edge to the edge
    // that samples done high.
    task automatic run_a(input logic [7:0] t, input logic [1:0] s,
                         input logic p, input logic h, input logic lp,
                         input logic [7:0] sw, input bit disturb,
                         output int lat, output int tg);
        int   n = 0;
        logic prev;
        wait_ready_a();
        tx = {8'h00, t};
        sel = s;
        pol = p;
        pha = h;
        loop_a = lp;
        slv = sw;
        s_cpol = p;
        s_cpha = h;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        prev = sck_a;
        lat = 0;
        tg = 0;
        while (lat == 0 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (sck_a != prev) tg++;
            prev = sck_a;
            if (disturb && n == 20) begin
                tx = ~tx;
                start_a = 1'b1;
                pha = ~pha;
                sel = sel + 2'd1;
            end
            if (disturb && n == 30) start_a = 1'b0;
            if (done_a) lat = n + 1;
        end
        chk("run_a_done_seen", lat != 0, 1);
    endtask

    int lat, tg, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!ready_a && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 4) start_a = 1'b1;
            if (n == 5) start_a = 1'b0;
        end
        chk("init_hold_cycles", n, H);
        chk("init_ready_b", ready_b, 1);
        repeat (3) @(negedge clk);
        chk("start_in_init_ignored", ready_a, 1);

        run_a(8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 0, lat, tg);
        chk("a5_latency", lat, 73);
        chk("a5_toggles", tg, 16);
        chk("a5_rx", rx_a, 8'hA5);

        for (int m = 0; m < 4; m++) begin
            run_a(8'h96, 2'd1, m[1], m[0], 1'b0, 8'h3C, 0, lat, tg);
            chk("mode_rx", rx_a, 8'h3C);
            chk("mode_toggles", tg, 16);
            chk("mode_idle_sck", sck_a, m[1]);
        end

        run_a(8'h5A, 2'd3, 1'b0, 1'b0, 1'b1, 8'h00, 0, lat, tg);
        chk("cs_oor_rx", rx_a, 8'h5A);
        chk("cs_oor_latency", lat, 73);

        run_a(8'hC3, 2'd2, 1'b1, 1'b1, 1'b1, 8'h00, 0, lat, tg);
        chk("cs2_rx", rx_a, 8'hC3);

        run_a(8'h69, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1, lat, tg);
        chk("disturb_rx", rx_a, 8'h69);
        chk("disturb_latency", lat, 73);
        repeat (10) @(negedge clk);
        chk("disturb_no_second", ready_a, 1);

        @(negedge clk);
        tx = 16'h8001;
        sel = 2'd2;
        pol = 1'b0;
        pha = 1'b0;
        start_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_b = 1'b0;
        chk("b_cs_active", cs_b, 4'b1011);
        n = 0;
        tg = 0;
        lat = 0;
        begin
            logic prev_b;
            prev_b = sck_b;
            while (lat == 0 && n < 400) begin
                @(posedge clk);
                #1;
                n++;
                if (sck_b != prev_b) tg++;
                prev_b = sck_b;
                if (done_b) lat = n + 1;
            end
        end
        chk("b_latency", lat, 69);
        chk("b_toggles", tg, 32);
        chk("b_rx", rx_b, 16'h8001);
        chk("b_cs_released", cs_b, 4'hF);

        wait_ready_a();
        tx = 16'h00F0;
        sel = 2'd0;
        pol = 1'b1;
        pha = 1'b0;
        loop_a = 1'b1;
        start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (30) @(negedge clk);
        chk("pre_rst_cs", cs_a, 3'b110);
        rst_n = 1'b0;
        #1;
        chk("rst_cs", cs_a, 3'b111);
        chk("rst_sck", sck_a, 0);
        chk("rst_rx", rx_a, 8'h00);
        chk("rst_ready", ready_a, 0);
        chk("rst_mosi", mosi_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_a(8'h33, 2'd1, 1'b0, 1'b0, 1'b1, 8'h00, 0, lat, tg);
        chk("post_rst_rx", rx_a, 8'h33);
        chk("post_rst_latency", lat, 73);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
